// File: rtl/shifter_sched.sv
// Two-requester scheduler owning a WIDTH-bit bidirectional shift register.
// Build option: SHIFT_SCHED_RR_EN selects round-robin arbitration (default: fixed priority, A first).
module shifter_sched #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic             clk1,
  input  logic             Reset,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             dir_a,
  input  logic             dir_b,
  input  logic [CW-1:0]    cnt_a,
  input  logic [CW-1:0]    cnt_b,
  input  logic             fill_a,
  input  logic             fill_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             done_a,
  output logic             done_b,
  output logic [WIDTH-1:0] q,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_dir;
  logic             w_dir_nxt;
  logic             r_fill;
  logic             w_fill_nxt;
  logic             r_own_b;
  logic             w_own_b_nxt;
  logic             r_gnt_a;
  logic             r_gnt_b;
  logic             r_done_a;
  logic             r_done_b;
  logic             r_busy;
  logic             w_gnt_a_nxt;
  logic             w_gnt_b_nxt;
  logic             w_done_a_nxt;
  logic             w_done_b_nxt;
  logic             w_busy_nxt;
  logic             w_any_req;
  logic             w_pick_b;
  logic [WIDTH-1:0] w_sel_data;
  logic [CW-1:0]    w_sel_cnt;
  logic             w_sel_dir;
  logic             w_sel_fill;

  assign w_any_req = req_a | req_b;

`ifdef SHIFT_SCHED_RR_EN
  // r_last_b set means B was granted most recently; reset value hands first contention to A
  logic r_last_b;

  assign w_pick_b = req_b & (~req_a | ~r_last_b);

  always_ff @(posedge clk1 or negedge Reset) begin
    if (!Reset) begin
      r_last_b <= 1'b1;
    end else if (r_state == IDLE && w_any_req) begin
      r_last_b <= w_pick_b;
    end
  end
`else
  assign w_pick_b = req_b & ~req_a;
`endif

  assign w_sel_data = w_pick_b ? data_b : data_a;
  assign w_sel_cnt  = w_pick_b ? cnt_b  : cnt_a;
  assign w_sel_dir  = w_pick_b ? dir_b  : dir_a;
  assign w_sel_fill = w_pick_b ? fill_b : fill_a;

  // State and datapath registers
  always_ff @(posedge clk1 or negedge Reset) begin
    if (!Reset) begin
      r_state  <= IDLE;
      r_q      <= '0;
      r_cnt    <= '0;
      r_dir    <= 1'b0;
      r_fill   <= 1'b0;
      r_own_b  <= 1'b0;
      r_gnt_a  <= 1'b0;
      r_gnt_b  <= 1'b0;
      r_done_a <= 1'b0;
      r_done_b <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_q      <= w_q_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dir    <= w_dir_nxt;
      r_fill   <= w_fill_nxt;
      r_own_b  <= w_own_b_nxt;
      r_gnt_a  <= w_gnt_a_nxt;
      r_gnt_b  <= w_gnt_b_nxt;
      r_done_a <= w_done_a_nxt;
      r_done_b <= w_done_b_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  // Next-state, datapath and pulse decode
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_fill_nxt  = r_fill;
    w_own_b_nxt = r_own_b;
    w_gnt_a_nxt = 1'b0;
    w_gnt_b_nxt = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_own_b_nxt = w_pick_b;
          w_q_nxt     = w_sel_data;
          w_cnt_nxt   = w_sel_cnt;
          w_dir_nxt   = w_sel_dir;
          w_fill_nxt  = w_sel_fill;
          w_gnt_a_nxt = ~w_pick_b;
          w_gnt_b_nxt = w_pick_b;
          w_state_nxt = (w_sel_cnt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        w_q_nxt   = r_dir ? {r_q[WIDTH-2:0], r_fill} : {r_fill, r_q[WIDTH-1:1]};
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt <= CW'(1)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // DONE is only ever entered for a single cycle, so this yields a one-cycle pulse
    w_done_a_nxt = (w_state_nxt == DONE) & ~w_own_b_nxt;
    w_done_b_nxt = (w_state_nxt == DONE) &  w_own_b_nxt;
    w_busy_nxt   = (w_state_nxt != IDLE);
  end

  assign gnt_a  = r_gnt_a;
  assign gnt_b  = r_gnt_b;
  assign done_a = r_done_a;
  assign done_b = r_done_b;
  assign q      = r_q;
  assign busy   = r_busy;

endmodule

// File: doc/shifter_sched.md
# shifter_sched

Two-requester scheduler that owns a WIDTH-bit bidirectional shift datapath and shares it between requesters A and B. A granted requester supplies a word, a direction, a shift count and a fill bit. The block loads the word, shifts it one position per clock, and returns the result with a done pulse. It sits between client logic and the shift register, so clients never drive the register's IN/MODE lines directly.

## Interface
- WIDTH, 4, datapath width; legal range 2..16
- CW, 3, shift-count width
- clk1  in  1  clock; all state changes on the rising edge
- Reset  in  1  asynchronous, active-low reset
- req_a, req_b  in  1  request; held high until the matching gnt pulse
- data_a, data_b  in  WIDTH  word to load
- dir_a, dir_b  in  1  1 = up (bit i takes bit i-1, bit 0 takes fill); 0 = down (bit i takes bit i+1, MSB takes fill)
- cnt_a, cnt_b  in  CW  number of shifts, 0..2^CW-1
- fill_a, fill_b  in  1  serial bit shifted in
- gnt_a, gnt_b  out  1  one-cycle grant pulse, registered
- done_a, done_b  out  1  one-cycle completion pulse, registered
- q  out  WIDTH  datapath register, continuously visible
- busy  out  1  high whenever state is not IDLE

## Operation
- State machine has three states: IDLE, SHIFT and DONE.
- Reset value of every output is 0: q, gnt_*, done_* and busy. State resets to IDLE and the round-robin pointer resets to "last = B".
- IDLE with no request: hold. q keeps its value.
- IDLE with a request on an edge:
  - The arbiter picks the winner.
  - q takes that requester's data; dir, cnt and fill are captured.
  - The winner's gnt goes high for the following cycle.
  - Next state is SHIFT if cnt != 0, otherwise DONE.
- SHIFT: on each edge, q shifts one place in the captured direction, with fill entering, and the remaining count decrements. The edge that performs the last shift moves the FSM to DONE.
- DONE: the winner's done is high for exactly one cycle and q holds the result. Next state is IDLE.
- When cnt >= WIDTH, the result is all fill bits.
- Requests seen while busy are ignored, not queued. A request still held is arbitrated at the next IDLE edge.
- gnt_a and gnt_b are never both high; the same holds for done_a and done_b.
- Inputs of the winner are don't-care after its gnt pulse.
- Reset asserted mid-operation clears everything immediately. No done pulse is produced for the aborted operation.

## Timing
- E0 is the IDLE edge that captures a request.
- The gnt pulse occupies the cycle after E0.
- Shifts occur on edges E1..Ecnt.
- The done pulse occupies the cycle after Ecnt; for cnt = 0 it is the cycle after E0, coinciding with gnt.
- Latency from E0 to the start of the done cycle is max(cnt,0)+1 edges; the FSM is back in IDLE after E(cnt+1).
- Minimum spacing between captures is cnt+2 edges, so one IDLE edge always separates operations.
- busy is high from the cycle after E0 through the done cycle inclusive.

## Configuration
- SHIFT_SCHED_RR_EN defined: round-robin arbitration.
  - If both requests are high in IDLE, the requester not granted last wins.
  - The pointer updates on every grant.
  - First contention after reset goes to A.
- SHIFT_SCHED_RR_EN undefined: fixed priority, A always beats B. The pointer logic is removed.
- The port list is identical in both builds.

## Test plan
- Reset and load:
  - Stimulus: assert Reset=0 with random inputs, release it, then issue A with data=1011, dir=1, cnt=2, fill=0.
  - Required response: all outputs are 0 during reset. gnt_a is high in the cycle after E0. q steps 1011 -> 0110 -> 1100. done_a is high one cycle with q=1100, then busy drops.
- Down shift with fill, then saturation:
  - Stimulus: B with data=1011, dir=0, cnt=1, fill=1. Then B with data=0000, dir=1, cnt=5, fill=1.
  - Required response: first result is q=1101 with done_b. Second result is q=1111.
- Zero count:
  - Stimulus: A with data=0110, cnt=0.
  - Required response: gnt_a and done_a are high in the same cycle, q=0110, and the FSM is in IDLE on the next edge.
- Contention:
  - Stimulus: req_a and req_b held high continuously.
  - Required response with SHIFT_SCHED_RR_EN: grants alternate A, B, A, B.
  - Required response without it: every grant goes to A and B starves.
  - In both builds, gnt_a and gnt_b are never both high.
- Reset mid-operation:
  - Stimulus: A with cnt=7, then Reset=0 during the third shift cycle.
  - Required response: q=0 and busy=0 immediately, with no done_a. After release, a new B request completes normally.
